// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle field layout and datapath offsets
// used by every stage register in the core.
package pipe_pkg;

  localparam int unsigned RD_W         = 5;
  localparam int unsigned REG_IN_SEL_W = 2;
  localparam int unsigned DWE_W        = 4;
  localparam int unsigned FUNC3_W      = 3;

  localparam int unsigned RD_LSB         = 0;
  localparam int unsigned REG_IN_SEL_LSB = RD_LSB + RD_W;
  localparam int unsigned DWE_LSB        = REG_IN_SEL_LSB + REG_IN_SEL_W;
  localparam int unsigned FUNC3_LSB      = DWE_LSB + DWE_W;
  localparam int unsigned MEM_REG_BIT    = FUNC3_LSB + FUNC3_W;
  localparam int unsigned REG_WR_BIT     = MEM_REG_BIT + 1;
  localparam int unsigned CTRL_BUNDLE_W  = REG_WR_BIT + 1;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ALU_OUT_LSB  = 0;
  localparam int unsigned RV2_LSB      = ALU_OUT_LSB + WORD_W;
  localparam int unsigned PC_IMM_LSB   = RV2_LSB + WORD_W;
  localparam int unsigned IMM_LSB      = PC_IMM_LSB + WORD_W;
  localparam int unsigned ALU_ZERO_BIT = IMM_LSB + WORD_W;
  localparam int unsigned EXMEM_DATA_W = ALU_ZERO_BIT + 1;

  typedef struct packed {
    logic                    reg_wr;
    logic                    mem_reg;
    logic [FUNC3_W-1:0]      func3;
    logic [DWE_W-1:0]        dwe;
    logic [REG_IN_SEL_W-1:0] reg_in_sel;
    logic [RD_W-1:0]         rd;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat interface carrying a datapath and a control bundle.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = CTRL_BUNDLE_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, data and ctrl with load and clear.
module pipe_slot
  import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned CTRL_W     = CTRL_BUNDLE_W,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Clear beats load so a kill always wins; ctrl is zeroed in the register itself.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) data_d = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, optional
// skid entry and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned CTRL_W     = CTRL_BUNDLE_W,
    parameter bit          SKID_EN    = 1'b1,
    parameter bit          CLEAR_DATA = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 stall_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    pipe_stage_reg_if.slave      in_if,
    pipe_stage_reg_if.master     out_if
);
    logic              in_ready, in_fire, out_fire;
    logic              m_valid, m_load, m_clr;
    logic [DATA_W-1:0] m_data, m_data_in;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_in;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = m_valid & out_if.ready;

    // M refills from S first so the older beat always leaves before a newer one.
    assign m_load    = ~flush & ((in_fire & (~m_valid | out_fire)) | (out_fire & s_valid));
    assign m_clr     = flush | (out_fire & ~s_valid & ~in_fire);
    assign m_data_in = s_valid ? s_data : in_if.data;
    assign m_ctrl_in = s_valid ? s_ctrl : in_if.ctrl;

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (m_load),
        .clear_i (m_clr),
        .data_i  (m_data_in),
        .ctrl_i  (m_ctrl_in),
        .valid_o (m_valid),
        .data_o  (m_data),
        .ctrl_o  (m_ctrl)
    );

    if (SKID_EN) begin : g_skid
        logic s_load, s_clr, s_valid_d, in_ready_q;

        assign s_load    = ~flush & in_fire & m_valid & ~out_fire;
        assign s_clr     = flush | (out_fire & s_valid);
        assign s_valid_d = s_clr ? 1'b0 : (s_load ? 1'b1 : s_valid);

        pipe_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (s_load),
            .clear_i (s_clr),
            .data_i  (in_if.data),
            .ctrl_i  (in_if.ctrl),
            .valid_o (s_valid),
            .data_o  (s_data),
            .ctrl_o  (s_ctrl)
        );

        // Registered copy of ~S.valid keeps in_ready off any combinational path.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) in_ready_q <= 1'b1;
            else          in_ready_q <= ~s_valid_d;
        end

        assign in_ready = in_ready_q;
    end else begin : g_no_skid
        assign s_valid  = 1'b0;
        assign s_data   = '0;
        assign s_ctrl   = '0;
        assign in_ready = out_if.ready | ~m_valid;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (m_valid && !out_if.ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = m_valid;
    assign out_if.data  = m_data;
    assign out_if.ctrl  = m_ctrl;
    assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, combinational and narrow-counter builds.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) sk_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) sk_dn ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) cb_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) cb_dn ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) st_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) st_dn ();

    logic        sk_flush = 0, sk_clr = 0, cb_flush = 0, cb_clr = 0, st_flush = 0, st_clr = 0;
    logic [15:0] sk_cnt, cb_cnt;
    logic [3:0]  st_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CLEAR_DATA(1'b0), .CNT_W(16))
    dut_skid (.clk(clk), .reset_n(reset_n), .flush(sk_flush), .stall_clr(sk_clr),
              .stall_cnt(sk_cnt), .in_if(sk_up), .out_if(sk_dn));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CLEAR_DATA(1'b1), .CNT_W(16))
    dut_comb (.clk(clk), .reset_n(reset_n), .flush(cb_flush), .stall_clr(cb_clr),
              .stall_cnt(cb_cnt), .in_if(cb_up), .out_if(cb_dn));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CLEAR_DATA(1'b0), .CNT_W(4))
    dut_sat (.clk(clk), .reset_n(reset_n), .flush(st_flush), .stall_clr(st_clr),
             .stall_cnt(st_cnt), .in_if(st_up), .out_if(st_dn));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sk_up.valid = 0; sk_up.data = '0; sk_up.ctrl = '0; sk_dn.ready = 1;
        cb_up.valid = 0; cb_up.data = '0; cb_up.ctrl = '0; cb_dn.ready = 1;
        st_up.valid = 0; st_up.data = '0; st_up.ctrl = '0; st_dn.ready = 1;
        reset_n = 0;
        step();
        step();
        checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sk_dn.valid); end
        checks++; if (sk_dn.data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", sk_dn.data); end
        checks++; if (sk_dn.ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", sk_dn.ctrl); end
        checks++; if (sk_up.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", sk_up.ready); end
        checks++; if (sk_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", sk_cnt); end
        checks++; if (cb_up.ready !== 1'b1) begin errors++; $display("FAIL reset_comb_in_ready: got %b want 1", cb_up.ready); end
        reset_n = 1;
        step();
    endtask

    task automatic test_streaming();
        sk_dn.ready = 1;
        for (int i = 0; i < 8; i++) begin
            sk_up.valid = 1; sk_up.data = 32'h10 + i; sk_up.ctrl = 16'(i + 1);
            step();
            checks++; if (sk_dn.valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, sk_dn.valid); end
            checks++; if (sk_dn.data !== 32'h10 + i) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, sk_dn.data, 32'h10 + i); end
        end
        sk_up.valid = 0;
        step();
        checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", sk_dn.valid); end
        checks++; if (sk_dn.ctrl !== 16'h0) begin errors++; $display("FAIL stream_drain_ctrl: got %h want 0", sk_dn.ctrl); end
        checks++; if (sk_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d want 0", sk_cnt); end
    endtask

    task automatic test_backpressure();
        sk_clr = 1; step(); sk_clr = 0;
        sk_dn.ready = 1; sk_up.valid = 1; sk_up.data = 32'hA; sk_up.ctrl = 16'h1;
        step();
        sk_dn.ready = 0; sk_up.data = 32'hB; sk_up.ctrl = 16'h2;
        step();
        sk_up.valid = 0;
        checks++; if (sk_up.ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", sk_up.ready); end
        checks++; if (sk_dn.data !== 32'hA) begin errors++; $display("FAIL bp_hold_a: got %h want a", sk_dn.data); end
        step();
        step();
        checks++; if (sk_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 3", sk_cnt); end
        checks++; if (sk_dn.data !== 32'hA) begin errors++; $display("FAIL bp_first_a: got %h want a", sk_dn.data); end
        sk_dn.ready = 1;
        step();
        checks++; if (sk_dn.data !== 32'hB || sk_dn.valid !== 1'b1) begin errors++; $display("FAIL bp_second_b: got %h/%b want b/1", sk_dn.data, sk_dn.valid); end
        checks++; if (sk_up.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", sk_up.ready); end
        step();
        checks++; if (sk_dn.valid !== 1'b0 || sk_dn.ctrl !== 16'h0) begin errors++; $display("FAIL bp_empty: got %b/%h want 0/0", sk_dn.valid, sk_dn.ctrl); end
    endtask

    task automatic test_flush();
        sk_dn.ready = 0; sk_up.valid = 1; sk_up.data = 32'hD; sk_up.ctrl = 16'hFFFF;
        step();
        checks++; if (sk_dn.ctrl !== 16'hFFFF) begin errors++; $display("FAIL flush_held_ctrl: got %h want ffff", sk_dn.ctrl); end
        sk_flush = 1; sk_up.data = 32'hC; sk_up.ctrl = 16'h1234;
        step();
        sk_flush = 0; sk_up.valid = 0;
        checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", sk_dn.valid); end
        checks++; if (sk_dn.ctrl !== 16'h0) begin errors++; $display("FAIL flush_ctrl: got %h want 0", sk_dn.ctrl); end
        checks++; if (sk_dn.data !== 32'hD) begin errors++; $display("FAIL flush_data_hold: got %h want d", sk_dn.data); end
        sk_dn.ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL flush_no_c[%0d]: got valid %b data %h want 0", i, sk_dn.valid, sk_dn.data); end
        end
    endtask

    task automatic test_reset_mid();
        sk_dn.ready = 0; sk_up.valid = 1; sk_up.data = 32'hE; sk_up.ctrl = 16'h3;
        step();
        sk_up.data = 32'hF; sk_up.ctrl = 16'h5;
        step();
        sk_up.valid = 0;
        checks++; if (sk_up.ready !== 1'b0) begin errors++; $display("FAIL rst_mid_full: got in_ready %b want 0", sk_up.ready); end
        #2 reset_n = 0;
        #1;
        checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got %b want 0", sk_dn.valid); end
        step();
        checks++; if (sk_dn.ctrl !== 16'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h want 0", sk_dn.ctrl); end
        checks++; if (sk_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", sk_cnt); end
        checks++; if (sk_up.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", sk_up.ready); end
        reset_n = 1; sk_dn.ready = 1;
        step();
        checks++; if (sk_dn.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: got %b data %h want 0", sk_dn.valid, sk_dn.data); end
    endtask

    task automatic test_saturation();
        st_dn.ready = 0; st_up.valid = 1; st_up.data = 32'h55; st_up.ctrl = 16'h1;
        step();
        st_up.valid = 0;
        repeat (14) step();
        checks++; if (st_cnt !== 4'd14) begin errors++; $display("FAIL sat_count14: got %0d want 14", st_cnt); end
        repeat (6) step();
        checks++; if (st_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold15: got %0d want 15", st_cnt); end
        st_clr = 1;
        step();
        st_clr = 0;
        checks++; if (st_cnt !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", st_cnt); end
        step();
        checks++; if (st_cnt !== 4'd1) begin errors++; $display("FAIL sat_restart: got %0d want 1", st_cnt); end
    endtask

    task automatic test_comb();
        cb_dn.ready = 0; cb_up.valid = 1; cb_up.data = 32'h61; cb_up.ctrl = 16'h21;
        step();
        cb_up.data = 32'h62; cb_up.ctrl = 16'h22;
        #1;
        checks++; if (cb_up.ready !== 1'b0) begin errors++; $display("FAIL comb_ready_low: got %b want 0", cb_up.ready); end
        cb_dn.ready = 1;
        #1;
        checks++; if (cb_up.ready !== 1'b1) begin errors++; $display("FAIL comb_ready_high: got %b want 1", cb_up.ready); end
        checks++; if (cb_dn.data !== 32'h61) begin errors++; $display("FAIL comb_first: got %h want 61", cb_dn.data); end
        step();
        cb_up.valid = 0;
        checks++; if (cb_dn.data !== 32'h62 || cb_dn.ctrl !== 16'h22) begin errors++; $display("FAIL comb_replace: got %h/%h want 62/22", cb_dn.data, cb_dn.ctrl); end
        step();
        checks++; if (cb_dn.valid !== 1'b0 || cb_dn.ctrl !== 16'h0 || cb_dn.data !== 32'h0) begin errors++; $display("FAIL comb_drain_zero: got %b/%h/%h want 0/0/0", cb_dn.valid, cb_dn.ctrl, cb_dn.data); end
        cb_dn.ready = 0; cb_up.valid = 1; cb_up.data = 32'h77; cb_up.ctrl = 16'hFFFF;
        step();
        cb_up.valid = 0; cb_flush = 1;
        step();
        cb_flush = 0;
        checks++; if (cb_dn.valid !== 1'b0 || cb_dn.ctrl !== 16'h0 || cb_dn.data !== 32'h0) begin errors++; $display("FAIL comb_flush_zero: got %b/%h/%h want 0/0/0", cb_dn.valid, cb_dn.ctrl, cb_dn.data); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_comb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces the fixed per-stage interface registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a datapath bundle and a control bundle, plus a valid bit and a valid/ready handshake for stall and backpressure.
- Supports synchronous flush for branch and jump kill, and an optional skid entry so that in_ready is registered.
- Guarantees that bubbles carry all-zero control, so no spurious register-file or memory writes occur.

Parameters:
- DATA_W, 128: width of the datapath bundle (for example alu_out, rv2, pc_imm, imm plus the alu_zero bit).
- CTRL_W, 16: width of the control bundle (rd, reg_in_sel, dwe, func3, mem_reg, reg_wr).
- SKID_EN, 1: 1 adds a second entry and makes in_ready a flop output; 0 gives a single entry with combinational in_ready.
- CLEAR_DATA, 0: 1 zeroes the data bundle on flush and drain; 0 holds the last data value.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of all held beats.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept a beat.
- in_data, input, DATA_W: upstream datapath bundle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: downstream beat present.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, DATA_W: registered datapath bundle.
- out_ctrl, output, CTRL_W: registered control bundle; equals 0 whenever out_valid=0.
- stall_cnt, output, CNT_W: count of cycles with out_valid & ~out_ready; saturates at all-ones.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. The block holds a main entry M and, when SKID_EN=1, a skid entry S. Each entry has a valid bit, data and ctrl.
- Reset (reset_n=0, asynchronous):
  - M.valid, S.valid, all data, all ctrl and stall_cnt go to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_ctrl=0.
  - in_ready=1 when SKID_EN=1; when SKID_EN=0 it follows its normal equation, giving 1 because out_valid=0.
  - Reset mid-transfer discards every beat.
- Latency: one cycle from in_fire to out_valid when the stage is empty. Throughput is one beat per cycle with out_ready held at 1.
- SKID_EN=0:
  - in_ready = out_ready | ~M.valid, combinational.
  - On in_fire, M loads the input.
  - On out_fire without in_fire, M.valid goes to 0 and M.ctrl goes to 0.
- SKID_EN=1:
  - in_ready = ~S.valid, taken directly from a flop.
  - in_fire with M empty, or with M draining this cycle (out_fire): M loads the input.
  - in_fire with M full and no out_fire: S loads the input.
  - out_fire with S valid: M loads S; S.valid and S.ctrl go to 0. An in_fire cannot occur in the same cycle, because in_ready=0.
  - out_fire with S empty and no in_fire: M.valid and M.ctrl go to 0.
  - Order is always preserved: a beat in S never overtakes the beat in M.
- flush:
  - Highest priority after reset.
  - Clears M.valid and S.valid, and zeroes both ctrl fields. Data is zeroed only when CLEAR_DATA=1.
  - A beat presented on the flush cycle is dropped, even if in_ready=1 and upstream sees in_fire.
  - An out_fire in the flush cycle completes normally downstream; the beat is not re-sent.
  - Flush with the stage empty has no effect beyond the above.
- Bubble rule: out_ctrl = 0 whenever out_valid = 0. This is enforced by registered zeroing, never by output gating.
- Stall counter:
  - Increments by 1 on each cycle with out_valid & ~out_ready.
  - Holds at 2^CNT_W - 1 once it saturates.
  - stall_clr has priority over increment; the value is 0 on the cycle after stall_clr.
  - Flush does not clear the counter.
- in_data and in_ctrl are don't-care while in_valid=0; no X may propagate into valid bits.

Decomposition:
- Shared package pipe_pkg:
  - Control field widths: RD_W=5, REG_IN_SEL_W=2, DWE_W=4, FUNC3_W=3.
  - Bit offsets of each field inside the ctrl bundle: mem_reg and reg_wr as single bits, giving CTRL_W=16.
  - Data field offsets and a helper constant for the EX/MEM DATA_W (4×32 + 1 = 129).
- One sub-module, pipe_slot:
  - A single valid+data+ctrl register with load, clear and async active-low reset.
  - Instantiated once for M and, under generate when SKID_EN=1, once for S.

Test Plan:
- Reset and bubble check: assert reset_n=0 mid-stream with M and S full → next edge shows out_valid=0, out_ctrl=0, stall_cnt=0 and in_ready=1 (SKID_EN=1).
- Streaming: out_ready=1, in_valid=1 for 8 beats with data=0x10..0x17 → out_data shows the same values one cycle later with no gaps, and stall_cnt stays 0.
- Backpressure: SKID_EN=1 with beats A=0xA, B=0xB; drop out_ready for 3 cycles after A is in M.
  - B lands in S and in_ready goes to 0.
  - When out_ready returns, the output order is A then B.
  - stall_cnt=3.
- Flush with a held beat: M holds ctrl=0xFFFF and flush is pulsed while in_valid=1 with beat C → next cycle out_valid=0 and out_ctrl=0; C never appears at the output.
- Counter saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15. Then stall_clr=1 → stall_cnt=0.
- Combinational mode: SKID_EN=0 with out_valid=1 and out_ready=0 → in_ready=0 in the same cycle; raising out_ready → in_ready=1 in the same cycle, and the new beat replaces M on the next edge.
